// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 8-bit Harvard core: opcodes, 0xC-group sub-ops,
// fetch FSM states and the instruction-length predecode used by fetch and decode.
package isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_SHF  = 4'h6;
    localparam logic [3:0] OP_STK  = 4'h7;
    localparam logic [3:0] OP_IO   = 4'h8;
    localparam logic [3:0] OP_JC   = 4'h9;
    localparam logic [3:0] OP_LOOP = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_MEM  = 4'hC;
    localparam logic [3:0] OP_LDI  = 4'hD;
    localparam logic [3:0] OP_STI  = 4'hE;

    // ra field selects the sub-op inside the OP_MEM group; ra==3 is a 1-byte form
    localparam logic [1:0] RA_LDM = 2'd0;
    localparam logic [1:0] RA_LDD = 2'd1;
    localparam logic [1:0] RA_STD = 2'd2;

    typedef enum logic [1:0] {
        S_VEC   = 2'd0,
        S_FETCH = 2'd1,
        S_IMM   = 2'd2
    } fetch_state_t;

    function automatic logic is_two_byte(input logic [3:0] opcode, input logic [1:0] ra);
        return (opcode == OP_MEM) && (ra != 2'b11);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch + IF/ID register; packet valid one cycle after its last byte is addressed.
// stall freezes PC, FSM and IF/ID; redirect (ignored only in S_VEC) flushes and wins over stall.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [3:0]        if_opcode,
    output logic [1:0]        if_ra,
    output logic [1:0]        if_rb,
    output logic [DATA_W-1:0] if_imm,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_next
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W-1:0] hold_instr;
    logic [ADDR_W-1:0] hold_pc;
    logic              rdata_two_byte;

    // Wraps modulo 2^ADDR_W, so an opcode at the top of memory pulls its immediate from 0
    assign pc_inc         = pc + ADDR_W'(1);
    assign imem_addr      = (state == S_VEC) ? RESET_VEC_ADDR : pc;
    assign rdata_two_byte = is_two_byte(imem_rdata[7:4], imem_rdata[3:2]);

    assign if_opcode = if_instr[7:4];
    assign if_ra     = if_instr[3:2];
    assign if_rb     = if_instr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_VEC;
            pc         <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_imm     <= '0;
            if_pc      <= '0;
            if_pc_next <= '0;
        end else if (redirect_valid && (state != S_VEC)) begin
            // Any half-assembled 2-byte instruction is dropped by leaving S_IMM
            state    <= S_FETCH;
            pc       <= redirect_pc;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_imm   <= '0;
        end else if (!stall) begin
            case (state)
                S_VEC: begin
                    pc       <= ADDR_W'(imem_rdata);
                    state    <= S_FETCH;
                    if_valid <= 1'b0;
                end
                S_FETCH: begin
                    pc <= pc_inc;
                    if (rdata_two_byte) begin
                        hold_instr <= imem_rdata;
                        hold_pc    <= pc;
                        state      <= S_IMM;
                        if_valid   <= 1'b0;
                    end else begin
                        if_valid   <= 1'b1;
                        if_instr   <= imem_rdata;
                        if_imm     <= '0;
                        if_pc      <= pc;
                        if_pc_next <= pc_inc;
                    end
                end
                S_IMM: begin
                    pc         <= pc_inc;
                    state      <= S_FETCH;
                    if_valid   <= 1'b1;
                    if_instr   <= hold_instr;
                    if_imm     <= imem_rdata;
                    if_pc      <= hold_pc;
                    if_pc_next <= pc_inc;
                end
                default: begin
                    state    <= S_VEC;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset vector, 2-byte assembly, stall, redirect, wrap, reset mid-op.
module tb_fetch_unit;
    import isa_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       stall;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       if_valid;
    logic [7:0] if_instr;
    logic [3:0] if_opcode;
    logic [1:0] if_ra;
    logic [1:0] if_rb;
    logic [7:0] if_imm;
    logic [7:0] if_pc;
    logic [7:0] if_pc_next;

    logic [7:0] mem [0:255];
    int n_pass = 0;
    int n_total = 0;

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_VEC_ADDR(8'h00)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode), .if_ra(if_ra),
        .if_rb(if_rb), .if_imm(if_imm), .if_pc(if_pc), .if_pc_next(if_pc_next)
    );

    // Advance one clock and settle; inputs are driven and outputs sampled here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [7:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++;
        if ({if_valid, if_instr, if_imm, if_pc, if_pc_next} !== {1'b0, 8'h00, 8'h00, 8'h00, 8'h00}) begin
            $display("FAIL reset_values got v=%0b i=%h m=%h pc=%h pn=%h want 0/00/00/00/00",
                     if_valid, if_instr, if_imm, if_pc, if_pc_next);
        end else n_pass++;
        rst = 1'b0;
        n_total++;
        if (imem_addr !== 8'h00) $display("FAIL vec_addr got %h want 00", imem_addr);
        else n_pass++;
        step();
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 8'h10}) $display("FAIL vec_load got v=%0b a=%h want 0/10", if_valid, imem_addr);
        else n_pass++;
        step();
        n_total++;
        if ({if_valid, if_instr, if_imm, if_pc, if_pc_next, imem_addr} !== {1'b1, 8'h21, 8'h00, 8'h10, 8'h11, 8'h11}) begin
            $display("FAIL first_instr got v=%0b i=%h m=%h pc=%h pn=%h a=%h want 1/21/00/10/11/11",
                     if_valid, if_instr, if_imm, if_pc, if_pc_next, imem_addr);
        end else n_pass++;
    endtask

    task automatic test_two_byte();
        do_redirect(8'h20);
        n_total++;
        if ({if_valid, if_instr, imem_addr} !== {1'b0, 8'h00, 8'h20}) begin
            $display("FAIL redirect_flush got v=%0b i=%h a=%h want 0/00/20", if_valid, if_instr, imem_addr);
        end else n_pass++;
        step();
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 8'h21}) $display("FAIL two_byte_bubble got v=%0b a=%h want 0/21", if_valid, imem_addr);
        else n_pass++;
        step();
        n_total++;
        if ({if_valid, if_instr, if_imm, if_pc, if_pc_next} !== {1'b1, 8'hC4, 8'h5A, 8'h20, 8'h22}) begin
            $display("FAIL two_byte_pkt got v=%0b i=%h m=%h pc=%h pn=%h want 1/c4/5a/20/22",
                     if_valid, if_instr, if_imm, if_pc, if_pc_next);
        end else n_pass++;
        step();
        n_total++;
        if ({if_valid, if_instr, if_opcode, if_ra, if_rb, if_imm, if_pc, if_pc_next} !==
            {1'b1, 8'hCC, 4'hC, 2'd3, 2'd0, 8'h00, 8'h22, 8'h23}) begin
            $display("FAIL ra3_one_byte got v=%0b i=%h op=%h ra=%0d rb=%0d m=%h pc=%h pn=%h want 1/cc/c/3/0/00/22/23",
                     if_valid, if_instr, if_opcode, if_ra, if_rb, if_imm, if_pc, if_pc_next);
        end else n_pass++;
        step();
        n_total++;
        if ({if_valid, if_instr, if_pc, if_pc_next} !== {1'b1, 8'hF5, 8'h23, 8'h24}) begin
            $display("FAIL undef_op got v=%0b i=%h pc=%h pn=%h want 1/f5/23/24", if_valid, if_instr, if_pc, if_pc_next);
        end else n_pass++;
    endtask

    task automatic test_stall();
        do_redirect(8'h30);
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if ({if_valid, if_instr, if_pc, if_pc_next, imem_addr} !== {1'b1, 8'h21, 8'h30, 8'h31, 8'h31}) begin
                $display("FAIL stall_hold[%0d] got v=%0b i=%h pc=%h pn=%h a=%h want 1/21/30/31/31",
                         k, if_valid, if_instr, if_pc, if_pc_next, imem_addr);
            end else n_pass++;
        end
        stall = 1'b0;
        step();
        n_total++;
        if ({if_valid, if_instr, if_pc} !== {1'b1, 8'h22, 8'h31}) begin
            $display("FAIL stall_release got v=%0b i=%h pc=%h want 1/22/31", if_valid, if_instr, if_pc);
        end else n_pass++;
        step();
        n_total++;
        if ({if_valid, if_instr, if_pc} !== {1'b1, 8'h23, 8'h32}) begin
            $display("FAIL stall_next got v=%0b i=%h pc=%h want 1/23/32", if_valid, if_instr, if_pc);
        end else n_pass++;
    endtask

    task automatic test_redirect();
        do_redirect(8'h50);
        step();
        do_redirect(8'h40);
        n_total++;
        if ({if_valid, if_instr, imem_addr} !== {1'b0, 8'h00, 8'h40}) begin
            $display("FAIL redirect_mid_imm got v=%0b i=%h a=%h want 0/00/40", if_valid, if_instr, imem_addr);
        end else n_pass++;
        step();
        n_total++;
        if ({if_valid, if_instr, if_imm, if_pc} !== {1'b1, 8'h41, 8'h00, 8'h40}) begin
            $display("FAIL redirect_target got v=%0b i=%h m=%h pc=%h want 1/41/00/40", if_valid, if_instr, if_imm, if_pc);
        end else n_pass++;
        stall = 1'b1;
        do_redirect(8'h60);
        n_total++;
        if ({if_valid, if_instr, imem_addr} !== {1'b0, 8'h00, 8'h60}) begin
            $display("FAIL redirect_over_stall got v=%0b i=%h a=%h want 0/00/60", if_valid, if_instr, imem_addr);
        end else n_pass++;
        stall = 1'b0;
        step();
        n_total++;
        if ({if_valid, if_instr, if_pc} !== {1'b1, 8'h61, 8'h60}) begin
            $display("FAIL redirect_stall_target got v=%0b i=%h pc=%h want 1/61/60", if_valid, if_instr, if_pc);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        mem[8'h00] = 8'h77;
        do_redirect(8'hFF);
        step();
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 8'h00}) $display("FAIL wrap_addr got v=%0b a=%h want 0/00", if_valid, imem_addr);
        else n_pass++;
        step();
        n_total++;
        if ({if_valid, if_instr, if_imm, if_pc, if_pc_next, imem_addr} !== {1'b1, 8'hC0, 8'h77, 8'hFF, 8'h01, 8'h01}) begin
            $display("FAIL wrap_pkt got v=%0b i=%h m=%h pc=%h pn=%h a=%h want 1/c0/77/ff/01/01",
                     if_valid, if_instr, if_imm, if_pc, if_pc_next, imem_addr);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_redirect(8'h50);
        step();
        stall          = 1'b1;
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        step();
        n_total++;
        if ({if_valid, if_instr, if_imm, if_pc, if_pc_next, imem_addr} !== {1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}) begin
            $display("FAIL reset_mid_op got v=%0b i=%h m=%h pc=%h pn=%h a=%h want 0/00/00/00/00/00",
                     if_valid, if_instr, if_imm, if_pc, if_pc_next, imem_addr);
        end else n_pass++;
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        step();
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 8'h77}) $display("FAIL reset_mid_vec got v=%0b a=%h want 0/77", if_valid, imem_addr);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h10;
        mem[8'h10] = 8'h21;
        mem[8'h11] = 8'h22;
        mem[8'h20] = 8'hC4; mem[8'h21] = 8'h5A; mem[8'h22] = 8'hCC; mem[8'h23] = 8'hF5;
        mem[8'h30] = 8'h21; mem[8'h31] = 8'h22; mem[8'h32] = 8'h23;
        mem[8'h40] = 8'h41; mem[8'h41] = 8'h42;
        mem[8'h50] = 8'hC0; mem[8'h51] = 8'h99;
        mem[8'h60] = 8'h61;
        mem[8'hFF] = 8'hC0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        test_reset();
        test_two_byte();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
